// File: rtl/change_dispenser_if.sv
// Vending-controller / coin-hopper side signals of the change dispenser.
// The master drives transactions and hopper ready; the slave is the dispenser.
interface change_dispenser_if;
  logic [7:0] MO;
  logic [1:0] PO;
  logic       coin_rdy;
  logic       coin_vld;
  logic [1:0] coin_sel;
  logic       item_vld;
  logic [1:0] item_id;
  logic       busy;
  logic       done;
  logic       ovf;

  modport master (
    output MO, PO, coin_rdy,
    input  coin_vld, coin_sel, item_vld, item_id, busy, done, ovf
  );

  modport slave (
    input  MO, PO, coin_rdy,
    output coin_vld, coin_sel, item_vld, item_id, busy, done, ovf
  );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: releases the product as a one-cycle strobe and pays the
// change out one coin at a time, largest denomination first, over a
// valid/ready handshake. A single pending entry holds a transaction that
// arrives while a previous one is still being dispensed.
module change_dispenser #(
  parameter int unsigned D0 = 50,
  parameter int unsigned D1 = 10,
  parameter int unsigned D2 = 5,
  parameter int unsigned D3 = 1
) (
  input  logic               clk,
  input  logic               rst,
  change_dispenser_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DISPENSE, FINISH, LOADP} state_t;

  localparam logic [7:0] DEN0 = 8'(D0);
  localparam logic [7:0] DEN1 = 8'(D1);
  localparam logic [7:0] DEN2 = 8'(D2);
  localparam logic [7:0] DEN3 = 8'(D3);

  state_t     state, state_nxt;
  logic [7:0] remaining, remaining_nxt;
  logic       item_vld_q, item_vld_nxt;
  logic [1:0] item_id_q, item_id_nxt;
  logic       pend_vld, pend_vld_nxt;
  logic [7:0] pend_mo, pend_mo_nxt;
  logic [1:0] pend_po, pend_po_nxt;
  logic       ovf_q, ovf_nxt;

  logic       arrival;
  logic [1:0] sel;
  logic [7:0] denom;
  logic [7:0] rem_sub;

  assign arrival = (bus.MO != '0) || (bus.PO != '0);
  assign rem_sub = remaining - denom;

  // Pick the largest denomination that still fits into the remaining amount.
  always_comb begin
    sel   = 2'd3;
    denom = DEN3;
    if (remaining >= DEN0) begin
      sel   = 2'd0;
      denom = DEN0;
    end else if (remaining >= DEN1) begin
      sel   = 2'd1;
      denom = DEN1;
    end else if (remaining >= DEN2) begin
      sel   = 2'd2;
      denom = DEN2;
    end
  end

  // Next-state, capture/load of transactions and pending-buffer bookkeeping.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    item_vld_nxt  = 1'b0;
    item_id_nxt   = '0;
    pend_vld_nxt  = pend_vld;
    pend_mo_nxt   = pend_mo;
    pend_po_nxt   = pend_po;
    ovf_nxt       = ovf_q;

    unique case (state)
      IDLE: begin
        if (arrival) begin
          remaining_nxt = bus.MO;
          item_vld_nxt  = (bus.PO != '0);
          item_id_nxt   = bus.PO;
          state_nxt     = (bus.MO != '0) ? DISPENSE : FINISH;
        end
      end
      DISPENSE: begin
        if (bus.coin_rdy) begin
          remaining_nxt = rem_sub;
          if (rem_sub == '0) state_nxt = FINISH;
        end
      end
      FINISH: begin
        // An arrival in this cycle lands in an empty buffer below, so it
        // must also steer us to LOADP rather than back to IDLE.
        state_nxt = (pend_vld || arrival) ? LOADP : IDLE;
      end
      LOADP: begin
        remaining_nxt = pend_mo;
        item_vld_nxt  = (pend_po != '0);
        item_id_nxt   = pend_po;
        state_nxt     = (pend_mo != '0) ? DISPENSE : FINISH;
        pend_vld_nxt  = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase

    // Arrivals while busy; the LOADP slot is free because it is being drained.
    if (arrival && (state != IDLE)) begin
      if (!pend_vld || (state == LOADP)) begin
        pend_vld_nxt = 1'b1;
        pend_mo_nxt  = bus.MO;
        pend_po_nxt  = bus.PO;
      end else begin
        ovf_nxt = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      item_vld_q <= 1'b0;
      item_id_q  <= '0;
      pend_vld   <= 1'b0;
      pend_mo    <= '0;
      pend_po    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      remaining  <= remaining_nxt;
      item_vld_q <= item_vld_nxt;
      item_id_q  <= item_id_nxt;
      pend_vld   <= pend_vld_nxt;
      pend_mo    <= pend_mo_nxt;
      pend_po    <= pend_po_nxt;
      ovf_q      <= ovf_nxt;
    end
  end

  assign bus.coin_vld = (state == DISPENSE);
  assign bus.coin_sel = (state == DISPENSE) ? sel : '0;
  assign bus.item_vld = item_vld_q;
  assign bus.item_id  = item_id_q;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == FINISH);
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: the driver pushes expected items,
// coins and done markers computed by greedy division; the monitor pops and
// compares whenever the DUT presents an item, accepted coin or done strobe.
module tb_change_dispenser;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  change_dispenser_if bus();

  change_dispenser #(.D0(50), .D1(10), .D2(5), .D3(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int den[4] = '{50, 10, 5, 1};
  int exp_items[$];
  int exp_coins[$];
  int exp_done[$];
  int coins_pushed = 0, coins_seen = 0;
  int done_seen = 0, vld_cycles = 0, stall_cycles = 0;
  int last_item_cyc = -1, last_done_cyc = -1, first_coin_cyc = -1;
  bit prev_stall = 0, prev_vld = 0, prev_done = 0, prev_item = 0;
  int prev_sel = 0;
  bit rdy_rand = 0;
  logic rdy_level = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sample mid-cycle after the driver has settled coin_rdy.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_stall = 0; prev_vld = 0; prev_done = 0; prev_item = 0;
    end else begin
      if (prev_stall) begin
        check("coin_hold_vld", bus.coin_vld, 1);
        check("coin_hold_sel", bus.coin_sel, prev_sel);
      end
      if (bus.coin_vld) begin
        vld_cycles++;
        if (!prev_vld) first_coin_cyc = cyc;
      end
      if (bus.coin_vld && bus.coin_rdy) begin
        check("coin_expected", exp_coins.size() > 0, 1);
        if (exp_coins.size() > 0) check("coin_sel", bus.coin_sel, exp_coins.pop_front());
        coins_seen++;
      end else if (bus.coin_vld) begin
        stall_cycles++;
      end
      if (bus.item_vld) begin
        check("item_pulse", prev_item, 0);
        check("item_expected", exp_items.size() > 0, 1);
        if (exp_items.size() > 0) check("item_id", bus.item_id, exp_items.pop_front());
        last_item_cyc = cyc;
      end
      if (bus.done) begin
        check("done_pulse", prev_done, 0);
        check("done_expected", exp_done.size() > 0, 1);
        if (exp_done.size() > 0) check("done_coin_total", coins_seen, exp_done.pop_front());
        done_seen++;
        last_done_cyc = cyc;
      end
      prev_stall = bus.coin_vld && !bus.coin_rdy;
      prev_sel   = bus.coin_sel;
      prev_vld   = bus.coin_vld;
      prev_done  = bus.done;
      prev_item  = bus.item_vld;
    end
  end

  task automatic tick();
    @(negedge clk);
    bus.MO = '0;
    bus.PO = '0;
    bus.coin_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_level;
  endtask

  // Reference model: product strobe, greedy coin list, then a done marker.
  task automatic model_push(input int mo, input int po);
    int m;
    m = mo;
    if (po != 0) exp_items.push_back(po);
    for (int d = 0; d < 4; d++) begin
      int n;
      n = m / den[d];
      m = m % den[d];
      for (int k = 0; k < n; k++) exp_coins.push_back(d);
      coins_pushed += n;
    end
    exp_done.push_back(coins_pushed);
  endtask

  task automatic issue(input int mo, input int po, input bit accepted, output int e);
    bus.MO = 8'(mo);
    bus.PO = 2'(po);
    e = cyc + 1;
    if (accepted && (mo != 0 || po != 0)) model_push(mo, po);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    tick();
    while ((bus.busy || exp_coins.size() > 0 || exp_done.size() > 0 || exp_items.size() > 0) && n < 400) begin
      tick();
      n++;
    end
    check(name, n < 400, 1);
  endtask

  task automatic flush_model();
    exp_items.delete();
    exp_coins.delete();
    exp_done.delete();
    coins_pushed = 0;
    coins_seen = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e, x, d0, v0, s0, c0, n, issued;
    rst = 1'b1;
    bus.MO = '0;
    bus.PO = '0;
    bus.coin_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_coin_vld", bus.coin_vld, 0);
    check("rst_coin_sel", bus.coin_sel, 0);
    check("rst_item_vld", bus.item_vld, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ovf", bus.ovf, 0);
    tick();
    rst = 1'b0;

    // 87 with product 1, no backpressure.
    tick();
    issue(87, 1, 1, e);
    wait_idle("t1_timeout");
    check("t1_item_cyc", last_item_cyc, e);
    check("t1_first_coin_cyc", first_coin_cyc, e);
    check("t1_done_cyc", last_done_cyc, e + 7);
    check("t1_busy_after", bus.busy, 0);

    // Product only.
    v0 = vld_cycles;
    tick();
    issue(0, 2, 1, e);
    wait_idle("t2_timeout");
    check("t2_item_cyc", last_item_cyc, e);
    check("t2_done_cyc", last_done_cyc, e);
    check("t2_no_coins", vld_cycles - v0, 0);

    // 15 with four stalled cycles on the first coin.
    rdy_level = 1'b0;
    s0 = stall_cycles;
    tick();
    issue(15, 0, 1, e);
    repeat (4) tick();
    rdy_level = 1'b1;
    wait_idle("t3_timeout");
    check("t3_stall_cycles", stall_cycles - s0, 4);
    check("t3_first_coin_cyc", first_coin_cyc, e);
    check("t3_done_cyc", last_done_cyc, e + 6);

    // Arrival coincident with LOADP is stored.
    d0 = done_seen;
    tick();
    issue(20, 0, 1, e);
    tick();
    issue(5, 0, 1, x);
    n = 0;
    do begin
      tick();
      n++;
    end while (done_seen == d0 && n < 50);
    check("t6_first_done_seen", done_seen - d0, 1);
    issue(2, 0, 1, x);
    wait_idle("t6_timeout");
    check("t6_done_count", done_seen - d0, 3);
    check("t6_last_done_cyc", last_done_cyc, e + 9);
    check("t6_ovf", bus.ovf, 0);

    // Second arrival while buffer full is dropped.
    d0 = done_seen;
    tick();
    issue(60, 0, 1, e);
    tick();
    issue(7, 0, 1, x);
    tick();
    issue(3, 0, 0, x);
    wait_idle("t4_timeout");
    check("t4_ovf", bus.ovf, 1);
    check("t4_done_count", done_seen - d0, 2);

    // Reset mid-transaction.
    c0 = coins_seen;
    tick();
    issue(255, 0, 1, e);
    n = 0;
    while (coins_seen < c0 + 2 && n < 50) begin
      tick();
      n++;
    end
    check("t5_two_coins", coins_seen - c0, 2);
    rst = 1'b1;
    #1;
    check("t5_coin_vld", bus.coin_vld, 0);
    check("t5_coin_sel", bus.coin_sel, 0);
    check("t5_item_vld", bus.item_vld, 0);
    check("t5_item_id", bus.item_id, 0);
    check("t5_busy", bus.busy, 0);
    check("t5_done", bus.done, 0);
    check("t5_ovf", bus.ovf, 0);
    flush_model();
    d0 = done_seen;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("t5_no_done_after_rst", done_seen - d0, 0);
    v0 = vld_cycles;
    issue(1, 0, 1, e);
    wait_idle("t5b_timeout");
    check("t5b_done_count", done_seen - d0, 1);
    check("t5b_coin_cycles", vld_cycles - v0, 1);

    // Randomized traffic with random hopper backpressure; at most one
    // transaction queued behind the active one so nothing is dropped.
    rdy_rand = 1;
    d0 = done_seen;
    issued = 0;
    for (int i = 0; i < 600; i++) begin
      int mo, po, r;
      tick();
      if (issued - (done_seen - d0) < 2 && $urandom_range(0, 3) == 0) begin
        r  = $urandom_range(0, 9);
        mo = (r < 2) ? 0 : ((r < 4) ? $urandom_range(0, 10) : $urandom_range(0, 255));
        po = $urandom_range(0, 3);
        issue(mo, po, 1, e);
        if (mo != 0 || po != 0) issued++;
      end
    end
    wait_idle("rand_timeout");
    check("rand_done_count", done_seen - d0, issued);
    check("rand_ovf", bus.ovf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
